seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  Sits between a numeric source and the shared hex-to-7-seg decoder (bcd[3:0] in, active-low seg out).
//  Steps a single decoder across all digits, one digit per slot, with an all-off guard gap between digits.
//  Double-buffers the displayed value so updates apply only at frame boundaries; optional leading-zero blanking.
// PARAMETERS
//  N_DIGITS     8        number of digits scanned (>=2)
//  REFRESH_DIV  100000   clk cycles per digit slot, gap included (1 ms @ 100 MHz); must be > BLANK_GAP
//  BLANK_GAP    16       cycles per slot with all anodes off (anti-ghosting); must be >= 1
// PORTS
//  clk        in   1            system clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  value_in   in   4*N_DIGITS   hex nibbles; nibble i = digit i, digit 0 = rightmost/LSD
//  load       in   1            1-cycle strobe: capture value_in into shadow register
//  digit_en   in   N_DIGITS     per-digit enable mask; 0 = digit kept dark in its slot
//  lz_blank   in   1            1 = blank leading zero digits (digit 0 never blanked)
//  bcd_out    out  4            nibble to decoder input
//  anodes     out  N_DIGITS     active-low digit select; at most one bit low at any time
//  frame_tick out  1            1-cycle pulse when a new frame begins (index wraps to 0)
// BEHAVIOUR
//  Reset: state=GAP, cnt=0, idx=0, anodes=all 1, bcd_out=0, frame_tick=0, shadow=0, active=0, pending=0.
//  FSM, 2 states, free-running after reset:
//   GAP : anodes=all 1; cnt 0..BLANK_GAP-1; at cnt=BLANK_GAP-1 -> SHOW, cnt<=0.
//   SHOW: anodes[idx]=0 unless digit idx is dark; cnt 0..REFRESH_DIV-BLANK_GAP-1; at last count -> GAP,
//         cnt<=0, idx<=(idx==N_DIGITS-1)?0:idx+1.
//  Slot = REFRESH_DIV cycles; frame = N_DIGITS*REFRESH_DIV cycles. After reset release: BLANK_GAP dark cycles, then digit 0.
//  All outputs registered. bcd_out loads the next digit's nibble on the edge that enters GAP, so it is stable
//   >= BLANK_GAP cycles before its anode asserts; it holds through SHOW.
//  Digit idx is dark if digit_en[idx]==0 or it is blanked; a dark slot still takes full REFRESH_DIV time.
//  Leading-zero blanking (lz_blank=1): digit k blanked iff active nibbles k..N_DIGITS-1 are all 0 and k!=0.
//   Evaluated on active register, so it is frame-coherent.
//  Double buffer: load=1 -> shadow<=value_in, pending<=1. On the SHOW->GAP edge with idx==N_DIGITS-1 (wrap):
//   frame_tick<=1 for one cycle; if pending and no load on that edge: active<=shadow, pending<=0.
//  Simultaneous load and wrap: load wins; shadow<=value_in, pending stays 1, active unchanged; swap next frame.
//  Repeated loads within a frame: last one wins.
//  bcd_out for the new frame's digit 0 uses the post-swap active value.
//  Reset asserted mid-scan: all outputs return to reset values immediately (async); frame restarts at digit 0.
//  digit_en and lz_blank are sampled continuously; a change applies on the next GAP->SHOW edge.
// TESTING (bench params N_DIGITS=4, REFRESH_DIV=8, BLANK_GAP=2)
//  1 Reset/start: hold rst_n=0 -> anodes=4'b1111, bcd_out=0; release -> 2 cycles 1111, then 1110 for 6 cycles.
//  2 Scan order: load 16'h12AF, lz_blank=0, en=4'hF; after frame_tick -> (bcd,anodes) = (F,1110),(A,1101),
//    (2,1011),(1,0111); 1111 for 2 cycles between each; frame_tick every 32 cycles.
//  3 LZ blank: load 16'h0030, lz_blank=1 -> digits 3,2 dark (1111); digit1 shows 3, digit0 shows 0.
//    Load 16'h0000 -> only digit 0 lit.
//  4 Mid-frame load: load 16'h5555 at digit 1 slot -> old value shown until frame_tick, then 5 on every digit.
//    Load 16'h1111 same cycle as wrap edge -> old value kept one extra frame.
//  5 Mask/async reset: en=4'b1010 -> anodes never 1110/1011; assert rst_n mid-SHOW -> anodes=1111 before next clk edge.
//  Every cycle: assert $countones(~anodes)<=1.

Source files
------------

// File: rtl/seg_scan_if.sv
// Display scan bus: numeric source / mask inputs and the decoder/anode outputs.
interface seg_scan_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] value_in;
  logic                  load;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  lz_blank;
  logic [3:0]            bcd_out;
  logic [N_DIGITS-1:0]   anodes;
  logic                  frame_tick;

  // Source side: drives the value and display options, observes the scan
  modport master (
    output value_in, load, digit_en, lz_blank,
    input  bcd_out, anodes, frame_tick
  );

  // Scan controller side
  modport slave (
    input  value_in, load, digit_en, lz_blank,
    output bcd_out, anodes, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// One shared decoder is stepped across the digits with an all-off guard gap per slot;
// the displayed value is double-buffered and swapped only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_GAP   = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_GAP - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - BLANK_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  typedef logic [N_DIGITS-1:0][3:0] nibbles_t;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  nibbles_t            shadow_q, shadow_d;
  nibbles_t            active_q, active_d;
  logic                pending_q, pending_d;
  logic [N_DIGITS-1:0] anodes_q, anodes_d;
  logic [3:0]          bcd_q, bcd_d;
  logic                frame_tick_q, frame_tick_d;

  logic [N_DIGITS-1:0] lz_mask;
  logic                dark;

  // Leading-zero mask: digit k blanks when it and every digit above it are zero (digit 0 never)
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
      zero_above = zero_above && (active_q[k] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  // Current digit stays dark when masked off or leading-zero blanked
  assign dark = !bus.digit_en[idx_q] || (bus.lz_blank && lz_mask[idx_q]);

  // Next-state: slot sequencing, anode/decoder drive, double-buffer swap
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    anodes_d     = anodes_q;
    bcd_d        = bcd_q;
    frame_tick_d = 1'b0;

    unique case (state_q)
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d  = ST_SHOW;
          cnt_d    = '0;
          anodes_d = '1;
          if (!dark) begin
            anodes_d[idx_q] = 1'b0;
          end
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d  = ST_GAP;
          cnt_d    = '0;
          anodes_d = '1;
          if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            frame_tick_d = 1'b1;
            // A load landing on the wrap edge defers the swap by one frame
            if (pending_q && !bus.load) begin
              active_d  = shadow_q;
              pending_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          // Decoder input settles for the whole gap before the anode turns on
          bcd_d = active_d[idx_d];
        end
      end
      default: begin
        state_d = ST_GAP;
      end
    endcase

    if (bus.load) begin
      shadow_d  = bus.value_in;
      pending_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      anodes_q     <= '1;
      bcd_q        <= 4'h0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      anodes_q     <= anodes_d;
      bcd_q        <= bcd_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.anodes     = anodes_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned RD    = 8;
  localparam int unsigned BG    = 2;
  localparam int unsigned FRAME = N * RD;

  logic clk = 1'b0;
  logic rst_n;

  seg_scan_if #(.N_DIGITS(N)) bus ();

  seg_scan_ctrl #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .BLANK_GAP   (BG)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset release give slot/digit by plain arithmetic
  int unsigned e;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic        m_pending;
  logic [3:0]  exp_anodes;
  logic [3:0]  exp_bcd;
  logic        exp_tick;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e          = 0;
    m_shadow   = '0;
    m_active   = '0;
    m_pending  = 1'b0;
    exp_anodes = 4'hF;
    exp_bcd    = 4'h0;
    exp_tick   = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs present at that edge
  task automatic model_edge();
    int unsigned s;
    int unsigned slot;
    bit          dark;
    e++;
    s        = e % RD;
    slot     = (e / RD) % N;
    exp_tick = 1'b0;
    if (s == 0) begin
      if (slot == 0) begin
        exp_tick = 1'b1;
        if (m_pending && !bus.load) begin
          m_active  = m_shadow;
          m_pending = 1'b0;
        end
      end
      exp_anodes = 4'hF;
      exp_bcd    = 4'(m_active >> (4 * slot));
    end
    if (s == BG) begin
      dark = !bus.digit_en[slot] ||
             (bus.lz_blank && slot != 0 && (m_active >> (4 * slot)) == 16'h0);
      exp_anodes = dark ? 4'hF : ~(4'(1) << slot);
    end
    if (bus.load) begin
      m_shadow  = bus.value_in;
      m_pending = 1'b1;
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("anodes", 32'(bus.anodes), 32'(exp_anodes));
    check_eq("bcd_out", 32'(bus.bcd_out), 32'(exp_bcd));
    check_eq("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
    check_eq("onehot", 32'($countones(~bus.anodes) <= 1), 32'(1));
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Run until the frame position (edges mod frame) reaches m; at most one frame
  task automatic run_until(input int unsigned m);
    for (int i = 0; i < int'(FRAME); i++) begin
      if (e % FRAME == m) break;
      run_cycle();
    end
    check_eq("run_until_pos", e % FRAME, m);
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.value_in = v;
    bus.load     = 1'b1;
    run_cycle();
    bus.load     = 1'b0;
  endtask

  // Assert reset asynchronously, check outputs before any edge, release after two edges
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    check_eq("rst_anodes", 32'(bus.anodes), 32'h0000_000F);
    check_eq("rst_bcd", 32'(bus.bcd_out), 32'h0);
    check_eq("rst_tick", 32'(bus.frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.value_in = '0;
    bus.load     = 1'b0;
    bus.digit_en = 4'hF;
    bus.lz_blank = 1'b0;
    model_reset();
    #1;

    // Reset and start-up timing
    apply_reset();
    run_cycle();
    check_eq("start_gap", 32'(bus.anodes), 32'hF);
    run_cycle();
    check_eq("start_d0", 32'(bus.anodes), 32'hE);
    run_n(40);

    // Scan order with a full value
    run_until(4);
    load_val(16'h12AF);
    run_until(0);
    run_until(4);
    check_eq("scan_d0", {bus.bcd_out, bus.anodes}, {4'hF, 4'b1110});
    run_until(12);
    check_eq("scan_d1", {bus.bcd_out, bus.anodes}, {4'hA, 4'b1101});
    run_until(20);
    check_eq("scan_d2", {bus.bcd_out, bus.anodes}, {4'h2, 4'b1011});
    run_until(28);
    check_eq("scan_d3", {bus.bcd_out, bus.anodes}, {4'h1, 4'b0111});
    run_n(int'(FRAME));

    // Leading-zero blanking
    bus.lz_blank = 1'b1;
    run_until(4);
    load_val(16'h0030);
    run_until(0);
    run_until(12);
    check_eq("lz_d1", {bus.bcd_out, bus.anodes}, {4'h3, 4'b1101});
    run_until(20);
    check_eq("lz_d2_dark", 32'(bus.anodes), 32'hF);
    run_until(28);
    check_eq("lz_d3_dark", 32'(bus.anodes), 32'hF);
    run_until(4);
    load_val(16'h0000);
    run_until(0);
    run_until(4);
    check_eq("lz_zero_d0", {bus.bcd_out, bus.anodes}, {4'h0, 4'b1110});
    run_until(12);
    check_eq("lz_zero_d1", 32'(bus.anodes), 32'hF);
    bus.lz_blank = 1'b0;

    // Mid-frame load, then a load on the wrap edge
    run_until(12);
    load_val(16'h5555);
    run_until(28);
    check_eq("mid_old", 32'(bus.bcd_out), 32'h0);
    run_until(0);
    run_until(20);
    check_eq("mid_new", 32'(bus.bcd_out), 32'h5);
    run_until(FRAME - 1);
    load_val(16'h1111);
    run_until(4);
    check_eq("wrap_kept", 32'(bus.bcd_out), 32'h5);
    run_until(0);
    run_until(4);
    check_eq("wrap_swap", 32'(bus.bcd_out), 32'h1);

    // Digit mask and asynchronous reset mid-SHOW
    bus.digit_en = 4'b1010;
    run_n(2 * int'(FRAME));
    run_until(12);
    check_eq("mask_d1", 32'(bus.anodes), 32'b1101);
    apply_reset();
    bus.digit_en = 4'hF;
    run_n(10);

    // Randomized traffic
    for (int i = 0; i < 1200; i++) begin
      logic [15:0] v;
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(4))
          0: v = 16'($urandom) & 16'hFFFF;
          1: v = 16'($urandom) & 16'h0FFF;
          2: v = 16'($urandom) & 16'h00FF;
          3: v = 16'($urandom) & 16'h000F;
          default: v = 16'h0000;
        endcase
        load_val(v);
      end else begin
        if ($urandom_range(49) == 0) bus.digit_en = 4'($urandom);
        if ($urandom_range(49) == 0) bus.lz_blank = 1'($urandom);
        run_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
